// File: rtl/seq_gen_pkg.sv
// Shared types, defaults and helpers for the serial pattern transmitter.
// State encodings are plain 2-bit constants so older tools that lack enums can consume them.
package seq_gen_pkg;

    localparam int DEF_PAT_W = 16;
    localparam int DEF_CNT_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_GAP   = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Requested lengths beyond the pattern register are sent as a full-width pattern.
    function automatic int unsigned clamp_len(input int unsigned len_in, input int unsigned max_len);
        return (len_in > max_len) ? max_len : len_in;
    endfunction

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable MSB-first shift register with a remaining-bit counter.
// msb is the bit to put on the line at the coming edge; last means the pattern has no bits left.
module seq_shift_reg
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             restart,
    input  logic             shift,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    output logic             msb,
    output logic             last
);

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_W);

    logic [PAT_W-1:0] saved_reg;
    logic [PAT_W-1:0] work_reg;
    logic [PAT_W-1:0] aligned;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] idx_reg;

    // Left-align so the first bit to send always sits in the top position.
    assign aligned = pat << (FULL_LEN - len);

    // The first bit of a pattern leaves on the same edge that loads it, so bypass the register.
    always_comb begin
        msb = work_reg[PAT_W-1];
        if (load) begin
            msb = aligned[PAT_W-1];
        end else if (restart) begin
            msb = saved_reg[PAT_W-1];
        end
    end

    assign last = (idx_reg == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            saved_reg <= '0;
            work_reg  <= '0;
            len_reg   <= '0;
            idx_reg   <= '0;
        end else if (load) begin
            saved_reg <= aligned;
            work_reg  <= aligned << 1;
            len_reg   <= len;
            idx_reg   <= len - LEN_W'(1);
        end else if (restart) begin
            work_reg  <= saved_reg << 1;
            idx_reg   <= len_reg - LEN_W'(1);
        end else if (shift) begin
            work_reg  <= work_reg << 1;
            idx_reg   <= idx_reg - LEN_W'(1);
        end
    end

endmodule

// File: rtl/seq_gen_serial.sv
// Programmable serial pattern transmitter: sends a captured pattern MSB-first,
// repeated with optional idle gaps, under a start/busy/done handshake.
module seq_gen_serial
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] reps,
    input  logic [CNT_W-1:0] gap,
    output logic             x,
    output logic             x_vld,
    output logic             busy,
    output logic             done
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] reps_reg, reps_next;
    logic [CNT_W-1:0] gap_reg, gap_next;
    logic [CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic             x_reg, x_next;
    logic             x_vld_reg, x_vld_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic             load;
    logic             restart;
    logic             shift;
    logic             emit;
    logic             msb;
    logic             last;
    logic [LEN_W-1:0] len_c;

    assign len_c = LEN_W'(clamp_len(32'(len), 32'(PAT_W)));

    seq_shift_reg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .restart (restart),
        .shift   (shift),
        .pat     (pat),
        .len     (len_c),
        .msb     (msb),
        .last    (last)
    );

    // reps_reg counts repetitions still owed, including the one on the line.
    always_comb begin
        state_next   = state_reg;
        reps_next    = reps_reg;
        gap_next     = gap_reg;
        gap_cnt_next = gap_cnt_reg;
        load         = 1'b0;
        restart      = 1'b0;
        shift        = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b0;

        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        reps_next = reps;
                        gap_next  = gap;
                        if (len_c == '0 || reps == '0) begin
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = ST_SHIFT;
                            load       = 1'b1;
                            busy_next  = 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!last) begin
                        shift     = 1'b1;
                        busy_next = 1'b1;
                    end else if (reps_reg > CNT_W'(1)) begin
                        reps_next = reps_reg - CNT_W'(1);
                        busy_next = 1'b1;
                        if (gap_reg != '0) begin
                            state_next   = ST_GAP;
                            gap_cnt_next = gap_reg;
                        end else begin
                            restart = 1'b1;
                        end
                    end else begin
                        reps_next  = '0;
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                    end
                end
                ST_GAP: begin
                    busy_next = 1'b1;
                    if (gap_cnt_reg <= CNT_W'(1)) begin
                        restart      = 1'b1;
                        state_next   = ST_SHIFT;
                        gap_cnt_next = '0;
                    end else begin
                        gap_cnt_next = gap_cnt_reg - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign emit       = load | restart | shift;
    assign x_next     = emit & msb;
    assign x_vld_next = emit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            reps_reg    <= '0;
            gap_reg     <= '0;
            gap_cnt_reg <= '0;
            x_reg       <= 1'b0;
            x_vld_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            reps_reg    <= reps_next;
            gap_reg     <= gap_next;
            gap_cnt_reg <= gap_cnt_next;
            x_reg       <= x_next;
            x_vld_reg   <= x_vld_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign x     = x_reg;
    assign x_vld = x_vld_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

endmodule

// File: tb/tb_seq_gen_serial.sv
// Scoreboard bench for seq_gen_serial: stimulus queues expected bits/done pulses,
// a negedge monitor pops and compares them, and a 1010 detector model counts hits.
module tb_seq_gen_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] pat = '0;
    logic [4:0]  len = '0;
    logic [7:0]  reps = '0;
    logic [7:0]  gap = '0;
    logic        x, x_vld, busy, done;

    always #5 clk = ~clk;

    seq_gen_serial #(
        .PAT_W (16),
        .CNT_W (8),
        .LEN_W (5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .pat   (pat),
        .len   (len),
        .reps  (reps),
        .gap   (gap),
        .x     (x),
        .x_vld (x_vld),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        bit is_done;
        bit xb;
        int cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         busy_cnt = 0;
    int         hits = 0;
    int         hist_n = 0;
    logic [3:0] hist = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one comparison per presented bit or done pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (busy) begin
                busy_cnt++;
                hist = {hist[2:0], x};
                hist_n++;
                if (hist_n >= 4 && hist == 4'b1010) hits++;
            end
            if (x_vld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bit: unexpected x=%0b at cycle %0d, none required", x, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_done || x !== e.xb || cyc != e.cyc || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL bit: got x=%0b busy=%0b at cycle %0d, required done=%0b x=%0b busy=1 at cycle %0d",
                                 x, busy, cyc, e.is_done, e.xb, e.cyc);
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done: unexpected done at cycle %0d, none required", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_done || cyc != e.cyc || busy !== 1'b0 || x_vld !== 1'b0) begin
                        errors++;
                        $display("FAIL done: got done at cycle %0d busy=%0b, required done=%0b at cycle %0d busy=0",
                                 cyc, busy, e.is_done, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, expv);
        end
    endtask

    // Queue expectations and fire a start; returns base so cycle k sits at cyc == base + k.
    task automatic issue(input logic [15:0] p, input logic [4:0] l, input logic [7:0] r,
                         input logic [7:0] g, input int hold, input int max_bits,
                         input int exp_done, output int base);
        int lc;
        int nb;
        @(negedge clk);
        base     = cyc;
        busy_cnt = 0;
        hits     = 0;
        hist     = '0;
        hist_n   = 0;
        lc = (int'(l) > 16) ? 16 : int'(l);
        nb = 0;
        if (lc != 0 && r != 0) begin
            for (int rep = 0; rep < int'(r); rep++) begin
                for (int k = 0; k < lc; k++) begin
                    if (nb < max_bits)
                        exp_q.push_back('{is_done: 1'b0, xb: p[lc-1-k], cyc: base + 1 + rep*(lc + int'(g)) + k});
                    nb++;
                end
            end
        end
        if (exp_done > 0)
            exp_q.push_back('{is_done: 1'b1, xb: 1'b0, cyc: base + exp_done});
        pat   = p;
        len   = l;
        reps  = r;
        gap   = g;
        start = 1'b1;
        @(negedge clk);
        pat  = '0;
        len  = '0;
        reps = '0;
        gap  = '0;
        repeat (hold) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish(input string nm, input int exp_busy, input int exp_hits);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        chk({nm, " drain"}, exp_q.size(), 0);
        exp_q.delete();
        chk({nm, " busy_cycles"}, busy_cnt, exp_busy);
        chk({nm, " hits"}, hits, exp_hits);
        $display("xfer %s: busy_cycles=%0d hits=%0d checks=%0d errors=%0d", nm, busy_cnt, hits, checks, errors);
    endtask

    task automatic run(input string nm, input logic [15:0] p, input logic [4:0] l, input logic [7:0] r,
                       input logic [7:0] g, input int hold, input int exp_done,
                       input int exp_busy, input int exp_hits);
        int b;
        issue(p, l, r, g, hold, 1000, exp_done, b);
        finish(nm, exp_busy, exp_hits);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", int'({x, x_vld, busy, done}), 0);
        rst = 1'b1;

        //   name        pat       len    reps  gap  hold done busy hits
        run("p1010",     16'h000A, 5'd4,  8'd1, 8'd0, 0,  5,   4,   1);
        run("p1010101",  16'h0055, 5'd7,  8'd1, 8'd0, 0,  8,   7,   2);
        run("rep3_gap2", 16'h000A, 5'd4,  8'd3, 8'd2, 0,  17,  16,  3);
        run("b2b",       16'h000A, 5'd4,  8'd2, 8'd0, 0,  9,   8,   3);
        run("len0",      16'hFFFF, 5'd0,  8'd1, 8'd0, 0,  1,   0,   0);
        run("reps0",     16'h000A, 5'd4,  8'd0, 8'd1, 0,  1,   0,   0);
        run("len20",     16'hF00F, 5'd20, 8'd1, 8'd0, 0,  17,  16,  0);
        run("hold_start",16'h000A, 5'd4,  8'd1, 8'd0, 3,  5,   4,   1);

        // Abort during cycle 3 of an 8-bit pattern: three bits, then silence.
        issue(16'h00A5, 5'd8, 8'd1, 8'd0, 0, 3, 0, b);
        while (cyc != b + 3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        chk("abort outputs", int'({x_vld, busy, done}), 0);
        abort = 1'b0;
        finish("abort", 3, 0);

        // Reset in the gap after the first repetition.
        issue(16'h000A, 5'd4, 8'd2, 8'd3, 0, 4, 0, b);
        while (cyc != b + 6) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("rst async outputs", int'({x, x_vld, busy, done}), 0);
        @(negedge clk);
        chk("rst held outputs", int'({x, x_vld, busy, done}), 0);
        finish("rst_gap", 6, 1);
        rst = 1'b1;
        run("after_rst", 16'h000A, 5'd4, 8'd1, 8'd0, 0, 5, 4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
